// File: rtl/run_ctrl_pkg.sv
// Shared types and default sizing for the run controller.
// Optional feature macro: RUN_CTRL_TIMEOUT_EN (enables the TOUT abort path in run_ctrl).
package run_ctrl_pkg;

  localparam int unsigned DefAw     = 8;
  localparam int unsigned DefDw     = 8;
  localparam int unsigned DefCw     = 16;
  localparam int unsigned DefRstCyc = 2;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RESET_CPU,
    RUN,
    DONE,
    TOUT
  } run_state_t;

  // Width of a down-counter that must hold values 0..n-1.
  function automatic int unsigned down_cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/run_ctrl_sat_counter.sv
// Saturating up-counter used for the RUN cycle count.
// Ports:
//   clk_i  clock
//   rst_i  synchronous active-high reset (clears count)
//   clr_i  synchronous clear (priority over en_i)
//   en_i   increment enable; count sticks at all-ones
//   q_o    current count
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_d, q_q;

  always_comb begin
    q_d = q_q;
    if (clr_i) begin
      q_d = '0;
    end else if (en_i && (q_q != '1)) begin
      q_d = q_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/run_ctrl.sv
// Run controller: preloads data memory from the host, holds the CPU in reset for RST_CYC
// cycles, releases it, then waits for cpu_done_i while counting RUN cycles.
// Optional macro RUN_CTRL_TIMEOUT_EN adds a TIMEOUT-cycle abort into state TOUT.
// Ports:
//   clk_i, reset_i            clock, synchronous active-high reset
//   start_i, no_load_i        run request (honoured in IDLE/DONE/TOUT), skip-preload flag
//   load_valid_i/last_i/addr_i/data_i, load_ready_o   preload beat handshake
//   mem_wr_en_o/addr_o/dat_o  zero-latency data-memory write port
//   cpu_reset_o, cpu_done_i   processor reset and completion flag
//   busy_o, finished_o, timed_out_o, cycle_count_o    status
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int unsigned AW      = DefAw,
  parameter int unsigned DW      = DefDw,
  parameter int unsigned CW      = DefCw,
  parameter int unsigned RST_CYC = DefRstCyc,
  parameter int unsigned TIMEOUT = 16'hFFFF
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          start_i,
  input  logic          no_load_i,
  input  logic          load_valid_i,
  input  logic          load_last_i,
  input  logic [AW-1:0] load_addr_i,
  input  logic [DW-1:0] load_data_i,
  output logic          load_ready_o,
  output logic          mem_wr_en_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_dat_o,
  output logic          cpu_reset_o,
  input  logic          cpu_done_i,
  output logic          busy_o,
  output logic          finished_o,
  output logic          timed_out_o,
  output logic [CW-1:0] cycle_count_o
);

  localparam int unsigned RcW = down_cnt_w(RST_CYC);
  localparam logic [RcW-1:0] RcLoad = RcW'(RST_CYC - 1);

  run_state_t state_d, state_q;
  logic [RcW-1:0] rc_d, rc_q;
  logic cnt_clr, cnt_en;

  always_comb begin
    state_d      = state_q;
    rc_d         = rc_q;
    load_ready_o = 1'b0;
    mem_wr_en_o  = 1'b0;
    mem_addr_o   = load_addr_i;
    mem_dat_o    = load_data_i;
    cpu_reset_o  = 1'b1;
    busy_o       = 1'b0;
    finished_o   = 1'b0;
    timed_out_o  = 1'b0;
    cnt_clr      = 1'b0;
    cnt_en       = 1'b0;

    unique case (state_q)
      IDLE, DONE, TOUT: begin
        finished_o  = (state_q == DONE);
        timed_out_o = (state_q == TOUT);
        if (start_i) begin
          cnt_clr = 1'b1;
          if (no_load_i) begin
            state_d = RESET_CPU;
            rc_d    = RcLoad;
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        busy_o       = 1'b1;
        load_ready_o = 1'b1;
        mem_wr_en_o  = load_valid_i;
        if (load_valid_i && load_last_i) begin
          state_d = RESET_CPU;
          rc_d    = RcLoad;
        end
      end
      RESET_CPU: begin
        busy_o = 1'b1;
        if (rc_q == '0) begin
          state_d = RUN;
        end else begin
          rc_d = rc_q - 1'b1;
        end
      end
      RUN: begin
        busy_o      = 1'b1;
        cpu_reset_o = 1'b0;
        if (cpu_done_i) begin
          state_d = DONE;
        end else begin
          cnt_en = 1'b1;
`ifdef RUN_CTRL_TIMEOUT_EN
          // This edge's increment lands the count exactly on TIMEOUT.
          if (cycle_count_o == CW'(TIMEOUT - 1)) begin
            state_d = TOUT;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase

`ifndef RUN_CTRL_TIMEOUT_EN
    timed_out_o = 1'b0;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      rc_q    <= '0;
    end else begin
      state_q <= state_d;
      rc_q    <= rc_d;
    end
  end

  sat_counter #(
    .W(CW)
  ) u_cycle_cnt (
    .clk_i(clk_i),
    .rst_i(reset_i),
    .clr_i(cnt_clr),
    .en_i (cnt_en),
    .q_o  (cycle_count_o)
  );

endmodule

// File: tb/tb_run_ctrl.sv
// Directed self-checking bench for run_ctrl. A second instance with a 4-bit counter
// shares the stimulus and is only checked in the saturation scenario.
module tb_run_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, no_load, load_valid, load_last, cpu_done;
  logic [7:0] load_addr, load_data;
  logic       load_ready, mem_wr_en, cpu_reset, busy, finished, timed_out;
  logic [7:0] mem_addr, mem_dat;
  logic [15:0] cycle_count;

  logic       load_ready2, mem_wr_en2, cpu_reset2, busy2, finished2, timed_out2;
  logic [7:0] mem_addr2, mem_dat2;
  logic [3:0] cycle_count2;

  int errors = 0;
  int checks = 0;

  run_ctrl #(
    .AW(8), .DW(8), .CW(16), .RST_CYC(2), .TIMEOUT(8)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .start_i      (start),
    .no_load_i    (no_load),
    .load_valid_i (load_valid),
    .load_last_i  (load_last),
    .load_addr_i  (load_addr),
    .load_data_i  (load_data),
    .load_ready_o (load_ready),
    .mem_wr_en_o  (mem_wr_en),
    .mem_addr_o   (mem_addr),
    .mem_dat_o    (mem_dat),
    .cpu_reset_o  (cpu_reset),
    .cpu_done_i   (cpu_done),
    .busy_o       (busy),
    .finished_o   (finished),
    .timed_out_o  (timed_out),
    .cycle_count_o(cycle_count)
  );

  run_ctrl #(
    .AW(8), .DW(8), .CW(4), .RST_CYC(2), .TIMEOUT(16'hFFFF)
  ) dut4 (
    .clk_i        (clk),
    .reset_i      (reset),
    .start_i      (start),
    .no_load_i    (no_load),
    .load_valid_i (load_valid),
    .load_last_i  (load_last),
    .load_addr_i  (load_addr),
    .load_data_i  (load_data),
    .load_ready_o (load_ready2),
    .mem_wr_en_o  (mem_wr_en2),
    .mem_addr_o   (mem_addr2),
    .mem_dat_o    (mem_dat2),
    .cpu_reset_o  (cpu_reset2),
    .cpu_done_i   (cpu_done),
    .busy_o       (busy2),
    .finished_o   (finished2),
    .timed_out_o  (timed_out2),
    .cycle_count_o(cycle_count2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; no_load = 1'b0; load_valid = 1'b0; load_last = 1'b0;
    load_addr = '0; load_data = '0; cpu_done = 1'b0;
    steps(2);
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_finished", 32'(finished), 32'd0);
    chk("rst_timed_out", 32'(timed_out), 32'd0);
    chk("rst_load_ready", 32'(load_ready), 32'd0);
    chk("rst_wr_en", 32'(mem_wr_en), 32'd0);
    chk("rst_count", 32'(cycle_count), 32'd0);

    // 1: preload three beats, last on A2
    reset = 1'b0; load_valid = 1'b1; #1;
    chk("idle_valid_no_wr", 32'(mem_wr_en), 32'd0);
    load_valid = 1'b0;
    start = 1'b1; no_load = 1'b0;
    step();
    start = 1'b0;
    chk("load_ready", 32'(load_ready), 32'd1);
    chk("load_busy", 32'(busy), 32'd1);
    chk("load_no_beat", 32'(mem_wr_en), 32'd0);
    load_valid = 1'b1; load_addr = 8'd0; load_data = 8'h11; #1;
    chk("b0_wr", 32'(mem_wr_en), 32'd1);
    chk("b0_addr", 32'(mem_addr), 32'd0);
    chk("b0_dat", 32'(mem_dat), 32'h11);
    step();
    load_addr = 8'd1; load_data = 8'h22; #1;
    chk("b1_wr", 32'(mem_wr_en), 32'd1);
    chk("b1_dat", 32'(mem_dat), 32'h22);
    step();
    load_addr = 8'd2; load_data = 8'h33; load_last = 1'b1; #1;
    chk("b2_wr", 32'(mem_wr_en), 32'd1);
    chk("b2_addr", 32'(mem_addr), 32'd2);
    chk("b2_dat", 32'(mem_dat), 32'h33);
    step();
    load_valid = 1'b0; load_last = 1'b0;
    chk("rc1_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rc1_load_ready", 32'(load_ready), 32'd0);
    chk("rc1_busy", 32'(busy), 32'd1);
    step();
    chk("rc2_cpu_reset", 32'(cpu_reset), 32'd1);
    step();
    chk("run_cpu_reset", 32'(cpu_reset), 32'd0);
    chk("run_count0", 32'(cycle_count), 32'd0);

    // 2: done after 5 RUN edges
    step();
    chk("run_count1", 32'(cycle_count), 32'd1);
    steps(4);
    chk("run_count5", 32'(cycle_count), 32'd5);
    chk("run_not_fin", 32'(finished), 32'd0);
    cpu_done = 1'b1;
    step();
    cpu_done = 1'b0;
    chk("done_finished", 32'(finished), 32'd1);
    chk("done_count", 32'(cycle_count), 32'd5);
    chk("done_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    steps(10);
    chk("done_hold_count", 32'(cycle_count), 32'd5);
    chk("done_hold_fin", 32'(finished), 32'd1);

    // 3: no_load start with load_valid high
    start = 1'b1; no_load = 1'b1; load_valid = 1'b1; load_addr = 8'h5A; load_data = 8'hA5; #1;
    chk("nl_no_wr_done", 32'(mem_wr_en), 32'd0);
    step();
    start = 1'b0;
    chk("nl_rc_no_wr", 32'(mem_wr_en), 32'd0);
    chk("nl_rc_ready", 32'(load_ready), 32'd0);
    chk("nl_rc_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("nl_rc_count_clr", 32'(cycle_count), 32'd0);
    chk("nl_rc_fin", 32'(finished), 32'd0);
    step();
    chk("nl_rc2_cpu_reset", 32'(cpu_reset), 32'd1);
    step();
    load_valid = 1'b0;
    chk("nl_run_cpu_reset", 32'(cpu_reset), 32'd0);
    cpu_done = 1'b1;
    step();
    cpu_done = 1'b0;
    chk("nl_done_fin", 32'(finished), 32'd1);
    chk("nl_done_count0", 32'(cycle_count), 32'd0);

    // 4: reset mid-RUN, then mid-LOAD; start while busy ignored
    start = 1'b1; no_load = 1'b1;
    step();
    start = 1'b0;
    steps(2);
    chk("r4_run", 32'(cpu_reset), 32'd0);
    steps(2);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("r4_busy_start_count", 32'(cycle_count), 32'd3);
    chk("r4_busy_start_run", 32'(cpu_reset), 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("r4_run_rst_cpu", 32'(cpu_reset), 32'd1);
    chk("r4_run_rst_busy", 32'(busy), 32'd0);
    chk("r4_run_rst_count", 32'(cycle_count), 32'd0);
    chk("r4_run_rst_fin", 32'(finished), 32'd0);
    start = 1'b1; no_load = 1'b0;
    step();
    chk("r4_load_ready", 32'(load_ready), 32'd1);
    step();
    start = 1'b0;
    chk("r4_load_start_ign", 32'(load_ready), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("r4_load_rst_ready", 32'(load_ready), 32'd0);
    chk("r4_load_rst_busy", 32'(busy), 32'd0);
    chk("r4_load_rst_cpu", 32'(cpu_reset), 32'd1);
    step();
    chk("r4_idle_stays", 32'(busy), 32'd0);

`ifdef RUN_CTRL_TIMEOUT_EN
    // 5: timeout with TIMEOUT=8
    start = 1'b1; no_load = 1'b1;
    step();
    start = 1'b0;
    steps(2);
    steps(7);
    chk("t5_count7", 32'(cycle_count), 32'd7);
    chk("t5_not_tout", 32'(timed_out), 32'd0);
    step();
    chk("t5_tout", 32'(timed_out), 32'd1);
    chk("t5_count8", 32'(cycle_count), 32'd8);
    chk("t5_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("t5_busy", 32'(busy), 32'd0);
    steps(3);
    chk("t5_hold", 32'(cycle_count), 32'd8);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t5b_tout_clr", 32'(timed_out), 32'd0);
    chk("t5b_count_clr", 32'(cycle_count), 32'd0);
    steps(2);
    steps(7);
    cpu_done = 1'b1;
    step();
    cpu_done = 1'b0;
    chk("t5b_done_fin", 32'(finished), 32'd1);
    chk("t5b_done_tout", 32'(timed_out), 32'd0);
    chk("t5b_done_count", 32'(cycle_count), 32'd7);
`else
    // 6: saturation on the 4-bit instance, no timeout
    start = 1'b1; no_load = 1'b1;
    step();
    start = 1'b0;
    steps(2);
    steps(20);
    chk("s6_count4_sat", 32'(cycle_count2), 32'd15);
    chk("s6_count16", 32'(cycle_count), 32'd20);
    chk("s6_no_tout", 32'(timed_out2), 32'd0);
    chk("s6_still_run", 32'(busy2), 32'd1);
    cpu_done = 1'b1;
    step();
    cpu_done = 1'b0;
    chk("s6_done4", 32'(finished2), 32'd1);
    chk("s6_done4_count", 32'(cycle_count2), 32'd15);
    chk("s6_done16", 32'(finished), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
